// File: rtl/channel_window_accumulator_pkg.sv
// Shared constants, FSM encoding and pointer/count helpers for the channel window stages.
// Pure declarations; no latency and no flow control of its own.
package channel_window_accumulator_pkg;

    localparam int NUM_CHANNELS = 14;
    localparam int DATA_W       = 8;
    localparam int SAMPLES      = 10;
    localparam int CH_W         = 4;
    localparam int IDX_W        = $clog2(SAMPLES);
    localparam int CNT_W        = $clog2(SAMPLES + 1);
    localparam int SUM_W        = DATA_W + $clog2(SAMPLES);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVICT  = 2'd1,
        UPDATE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] p);
        return (p == IDX_LAST) ? '0 : p + IDX_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
        return (c == CNT_FULL) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/channel_sample_ram.sv
// Per-channel sample storage addressed by {channel, index}; read data registered (1 cycle).
// No flow control: the caller owns read/write timing.
module channel_sample_ram
    import channel_window_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 1 << (CH_W + IDX_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are never reset; stale entries are masked by the fill count upstream.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_ch, wr_idx}] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[{rd_ch, rd_idx}];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/channel_window_accumulator.sv
// Per-channel sliding-window sum over the last SAMPLES samples; result valid 3 cycles after accept.
// One sample in flight: in_ready low from accept until the result handshake; out_* held while stalled.
module channel_window_accumulator
    import channel_window_accumulator_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_channel,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_channel,
    output logic [SUM_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_full,
    output logic              err_bad_channel
);

    state_t state_q, state_d;

    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic [IDX_W-1:0]  wr_ptr_q [NUM_CHANNELS];
    logic [CNT_W-1:0]  cnt_q    [NUM_CHANNELS];
    logic [SUM_W-1:0]  sum_q    [NUM_CHANNELS];

    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_channel_q, out_channel_d;
    logic [SUM_W-1:0]  out_sum_q, out_sum_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;

    logic              legal_ch;
    logic              take;
    logic              ram_rd_en;
    logic              upd_en;
    logic [DATA_W-1:0] ram_rd_data;

    logic [IDX_W-1:0]  cur_ptr;
    logic [CNT_W-1:0]  cur_cnt;
    logic [SUM_W-1:0]  cur_sum;
    logic [DATA_W-1:0] old_eff;
    logic [SUM_W:0]    sum_ext;
    logic [SUM_W-1:0]  new_sum;

    assign legal_ch = ({1'b0, in_channel} < (CH_W + 1)'(NUM_CHANNELS));
    assign take     = in_ready && in_valid && !clear;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (take && legal_ch) state_d = EVICT;
                EVICT:   state_d = UPDATE;
                UPDATE:  state_d = OUTPUT;
                OUTPUT:  if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        ram_rd_en = 1'b0;
        upd_en    = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            EVICT:   ram_rd_en = !clear;
            UPDATE:  upd_en    = !clear;
            default: ;
        endcase
    end

    channel_sample_ram u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_ch   (ch_q),
        .rd_idx  (wr_ptr_q[ch_q]),
        .rd_data (ram_rd_data),
        .wr_en   (upd_en),
        .wr_ch   (ch_q),
        .wr_idx  (wr_ptr_q[ch_q]),
        .wr_data (data_q)
    );

    assign cur_ptr = wr_ptr_q[ch_q];
    assign cur_cnt = cnt_q[ch_q];
    assign cur_sum = sum_q[ch_q];

    // Slot being overwritten only contributes once the window has wrapped.
    assign old_eff = (cur_cnt == CNT_FULL) ? ram_rd_data : '0;
    assign sum_ext = {1'b0, cur_sum}
                   - {{(SUM_W + 1 - DATA_W){1'b0}}, old_eff}
                   + {{(SUM_W + 1 - DATA_W){1'b0}}, data_q};
    assign new_sum = sum_ext[SUM_W-1:0];

    always_comb begin
        ch_d   = ch_q;
        data_d = data_q;
        if (take && legal_ch) begin
            ch_d   = in_channel;
            data_d = in_data;
        end
        err_d = take && !legal_ch;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_channel_d = out_channel_q;
        out_sum_d     = out_sum_q;
        out_count_d   = out_count_q;
        if (clear) begin
            out_valid_d   = 1'b0;
            out_channel_d = '0;
            out_sum_d     = '0;
            out_count_d   = '0;
        end else if (upd_en) begin
            out_valid_d   = 1'b1;
            out_channel_d = ch_q;
            out_sum_d     = new_sum;
            out_count_d   = cnt_next(cur_cnt);
        end else if (state_q == OUTPUT && out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q          <= '0;
            data_q        <= '0;
            err_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_sum_q     <= '0;
            out_count_q   <= '0;
        end else begin
            ch_q          <= ch_d;
            data_q        <= data_d;
            err_q         <= err_d;
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_sum_q     <= out_sum_d;
            out_count_q   <= out_count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                sum_q[i]    <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                sum_q[i]    <= '0;
            end
        end else if (upd_en) begin
            wr_ptr_q[ch_q] <= ptr_next(cur_ptr);
            cnt_q[ch_q]    <= cnt_next(cur_cnt);
            sum_q[ch_q]    <= new_sum;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_channel     = out_channel_q;
    assign out_sum         = out_sum_q;
    assign out_count       = out_count_q;
    assign out_full        = (out_count_q == CNT_FULL);
    assign err_bad_channel = err_q;

endmodule

// File: tb/tb_channel_window_accumulator.sv
// Directed scoreboard bench for channel_window_accumulator: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every output handshake.
module tb_channel_window_accumulator;
    import channel_window_accumulator_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n, clear, in_valid, in_ready;
    logic [CH_W-1:0]   in_channel, out_channel;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready, out_full, err_bad_channel;
    logic [SUM_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;

    typedef struct { int ch; int sum; int cnt; } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int snap_sum, snap_ch, snap_cnt;

    always #5 clk = ~clk;

    channel_window_accumulator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_channel      (in_channel),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_channel     (out_channel),
        .out_sum         (out_sum),
        .out_count       (out_count),
        .out_full        (out_full),
        .err_bad_channel (err_bad_channel)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: compare every accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: ch=%0d sum=%0d cnt=%0d with no expectation queued",
                         out_channel, out_sum, out_count);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_channel", int'(out_channel), mon_e.ch);
                check("out_sum",     int'(out_sum),     mon_e.sum);
                check("out_count",   int'(out_count),   mon_e.cnt);
                check("out_full",    int'(out_full),    (mon_e.cnt == SAMPLES) ? 1 : 0);
            end
        end
    end

    // Drive one sample from just after a rising edge; returns just after the accepting edge.
    task automatic send(input int ch, input int d, input bit push, input int es, input int ec);
        int n;
        in_channel = CH_W'(ch);
        in_data    = DATA_W'(d);
        in_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ch=%0d in_ready=%0d after %0d cycles, required 1", ch, in_ready, n);
        end else if (push) begin
            sb_q.push_back('{ch, es, ec});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", int'(out_valid), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_channel = '0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready",  int'(in_ready), 1);
        check("rst_out_sum",   int'(out_sum), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_full",  int'(out_full), 0);
        check("rst_err",       int'(err_bad_channel), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill channel 3 with 1..10, then wrap twice.
        for (int k = 1; k <= 10; k++) send(3, k, 1, k * (k + 1) / 2, k);
        send(3, 100, 1, 154, 10);
        send(3, 0,   1, 152, 10);

        // Full-scale channel 0 interleaved with channel 13.
        for (int k = 1; k <= 10; k++) begin
            send(0,  255, 1, 255 * k, k);
            send(13, 7,   1, 7 * k,   k);
        end
        send(3, 5, 1, 154, 10);
        send(0, 0, 1, 2295, 10);

        // Illegal channel: dropped, one-cycle error pulse.
        send(14, 'hAA, 0, 0, 0);
        @(negedge clk);
        check("bad_ch_err_pulse", int'(err_bad_channel), 1);
        check("bad_ch_in_ready",  int'(in_ready), 1);
        check("bad_ch_no_valid",  int'(out_valid), 0);
        @(negedge clk);
        check("bad_ch_err_clears", int'(err_bad_channel), 0);
        repeat (3) begin
            @(negedge clk);
            check("bad_ch_still_no_valid", int'(out_valid), 0);
        end
        @(posedge clk); #1;
        send(5, 9, 1, 9, 1);

        // Output backpressure with a pending sample.
        wait_idle();
        out_ready = 1'b0;
        send(5, 1, 1, 10, 2);
        wait_valid();
        snap_sum = int'(out_sum);
        snap_ch  = int'(out_channel);
        snap_cnt = int'(out_count);
        @(posedge clk); #1;
        in_channel = 4'd5;
        in_data    = 8'd2;
        in_valid   = 1'b1;
        sb_q.push_back('{5, 12, 3});
        repeat (5) begin
            @(negedge clk);
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_out_sum",   int'(out_sum), snap_sum);
            check("hold_out_ch",    int'(out_channel), snap_ch);
            check("hold_out_count", int'(out_count), snap_cnt);
            check("hold_in_ready",  int'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("handshake_cycle_in_ready", int'(in_ready), 0);
        @(negedge clk);
        check("after_handshake_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pending_accepted", int'(in_ready), 0);

        // Clear while a result is stalled in OUTPUT.
        wait_idle();
        out_ready = 1'b0;
        send(8, 60, 0, 0, 0);
        wait_valid();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_out_valid", int'(out_valid), 0);
        check("clr_in_ready",  int'(in_ready), 1);
        check("clr_out_sum",   int'(out_sum), 0);
        check("clr_out_count", int'(out_count), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8, 33, 1, 33, 1);
        send(3, 4,  1, 4,  1);

        // Reset asserted while a sample is in UPDATE.
        send(7, 50, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_out_valid", int'(out_valid), 0);
        check("rstmid_in_ready",  int'(in_ready), 1);
        check("rstmid_out_count", int'(out_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(7, 20, 1, 20, 1);

        begin
            int n = 0;
            while (sb_q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("scoreboard_drained", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
